wb_retire_unit: RTL

- Write-back stage of the 16-bit pipeline.
- Consumes the outputs of the MEM/WB pipeline register, selects the result, and retires it into the register-file write port.
- The single write port is shared with the vector encryption unit. Scalar results that lose arbitration wait in a small retire FIFO, and the stage back-pressures the pipeline when that FIFO is full.

---
 rtl/wb_retire_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_retire_unit.sv
// rtl/wb_retire_unit.sv - write-back retire stage sharing the RF write port with the vector unit
// Optional forwarding search compiled in with `define WB_FWD_EN.
module wb_retire_unit #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regWrite_in,
  input  logic [1:0]  resultSrc_in,
  input  logic [3:0]  rd_in,
  input  logic [15:0] aluRes_in,
  input  logic [15:0] readData_in,
  input  logic [15:0] pc_plus2_in,
  input  logic [15:0] writeData_in,
  input  logic        vec_valid,
  input  logic [3:0]  vec_rd,
  input  logic [15:0] vec_data,
  output logic        vec_ready,
  output logic        wb_stall,
`ifdef WB_FWD_EN
  input  logic [3:0]  q_rs,
  output logic        fwd_hit,
  output logic [15:0] fwd_data,
`endif
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  logic [15:0]   fifo_data [DEPTH];
  logic [3:0]    fifo_rd   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [SW-1:0] starve_cnt;

  logic [15:0] sel;
  logic        full;
  logic        have_head;
  logic        accept;
  logic        scalar_cand;
  logic        forced;
  logic        vec_win;
  logic        scalar_win;
  logic        push;
  logic        pop;
  logic [15:0] cand_data;
  logic [3:0]  cand_rd;

  always_comb begin
    sel = writeData_in;
    case (resultSrc_in)
      2'b00:   sel = aluRes_in;
      2'b01:   sel = readData_in;
      2'b10:   sel = pc_plus2_in;
      default: sel = writeData_in;
    endcase
  end

  // Everything that can cause a write or a stall is gated by reset so the
  // combinational outputs read as idle while reset is asserted.
  always_comb begin
    full        = (count == (AW+1)'(DEPTH));
    have_head   = (count != '0);
    accept      = reset && regWrite_in && !full;
    scalar_cand = have_head || accept;
    forced      = (starve_cnt == SW'(STARVE_LIM));
    vec_win     = reset && vec_valid && (!scalar_cand || forced);
    scalar_win  = reset && scalar_cand && !vec_win;
    pop         = scalar_win && have_head;
    push        = accept && !(scalar_win && !have_head);
    cand_data   = have_head ? fifo_data[head] : sel;
    cand_rd     = have_head ? fifo_rd[head] : rd_in;
    vec_ready   = vec_win;
    wb_stall    = reset && full;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[tail] <= sel;
      fifo_rd[tail]   <= rd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= '0;
      rf_wd      <= '0;
    end else begin
      rf_we <= vec_win || scalar_win;
      if (vec_win) begin
        rf_wa <= vec_rd;
        rf_wd <= vec_data;
      end else if (scalar_win) begin
        rf_wa <= cand_rd;
        rf_wd <= cand_data;
      end
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (!vec_valid || vec_win)
        starve_cnt <= '0;
      else if (scalar_win && !forced)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef WB_FWD_EN
  // Entries later in FIFO order are younger, so the last match wins; the
  // registered write is older than anything still queued.
  logic [AW-1:0] fwd_idx;
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = head;
    if (rf_we && rf_wa == q_rs) begin
      fwd_hit  = 1'b1;
      fwd_data = rf_wd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head + AW'(i);
      if ((AW+1)'(i) < count && fifo_rd[fwd_idx] == q_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[fwd_idx];
      end
    end
  end
`endif

endmodule
